shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit storage register between N_REQ requesters. Each requester raises a request with its write data. The block grants one requester at a time and loads that requester's data into the register. It also presents the true and complemented register outputs. It sits between the requester-side logic and the flip-flop storage cells, and sequences every write into them.

## Interface
- N_REQ, 4: number of requesters (2..8)
- WIDTH, 8: register/data width
- PTR_W, $clog2(N_REQ): width of the grant index
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req  input  N_REQ  per-requester write request, level
- wdata  input  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant
- gnt_id  output  PTR_W  index of the current/last grantee
- wr_done  output  1  one-cycle pulse, register loaded this edge
- q  output  WIDTH  shared register value
- qbar  output  WIDTH  bitwise complement of q, always ~q
- busy  output  1  high while in GRANT

## Operation
- The only clocking and reset is one clock with an asynchronous, active-low reset `rst`.
- Reset values: gnt=0, gnt_id=0, wr_done=0, q=0, qbar={WIDTH{1}}, busy=0, rr pointer=0, state=IDLE.
- The FSM has two states, IDLE and GRANT.
- IDLE:
  - If req≠0, select the winner: the first set req bit at or after the pointer, searching upward with wrap.
  - Next state is GRANT, with gnt=onehot(winner) and gnt_id=winner.
  - If req=0, stay in IDLE.
- GRANT (one cycle):
  - At the closing edge, q <= wdata[gnt_id].
  - wr_done=1 in the following cycle.
  - pointer <= gnt_id+1, wrapping from N_REQ-1 to 0.
  - If req has any bit set other than the current grantee's, go directly to GRANT with the next winner. This gives back-to-back writes with 1 write per cycle.
  - Otherwise return to IDLE with gnt=0.
- The write occurs even if the grantee drops req during GRANT. wdata is sampled at the GRANT closing edge.
- Requester contract: hold req and wdata stable until gnt[i] is seen high. Drop req in the cycle after the grant, or the requester is re-queued by round-robin.
- A single persistent requester with no competitors re-wins after passing through IDLE: 1 write every 2 cycles.
- Reset asserted mid-GRANT:
  - Immediately clear all state; q returns to 0.
  - No wr_done is produced.
- qbar is derived combinationally from q and is never independently stored.

## Timing
- req sampled at edge k, in IDLE → gnt high after edge k.
- q updates at edge k+1 → wr_done high after edge k+1. Latency from req to q is 2 edges.
- gnt, gnt_id, busy and wr_done are all registered. No combinational path from req to gnt.
- Fairness: with all N_REQ requests held continuously, each requester is granted exactly once per N_REQ consecutive grants.
- Reset release is synchronous-safe. The first grant is possible at the second rising edge after rst rises.

## Configuration
- SHARED_REG_LOCK_EN: adds input `lock [N_REQ]`.
  - While in GRANT, if lock[gnt_id]=1 and req[gnt_id]=1, the same requester keeps the grant for the next cycle and the pointer does not advance. Each such cycle is a write.
  - The lock ends when lock or req drops; the next winner is then chosen normally.
  - A lock is limited to 16 consecutive writes, after which the pointer advances regardless.
- Without the macro: no lock port, and pure round-robin as above.

## Structure
- Package shared_reg_pkg holds:
  - the state enum (IDLE, GRANT);
  - the LOCK_MAX=16 constant;
  - a function `rr_pick(req, ptr)` returning the winner index.
- Sub-module rr_picker: combinational round-robin priority encoder, with inputs req and pointer and output winner and valid. It is reused by other arbiters in the design.
- The storage register, plus the qbar derivation, is an array of reset-to-0 flip-flops inside the top.

## Test plan
- Reset: rst=0 at t=0, release after 10 cycles → q=0x00, qbar=0xFF, gnt=0, busy=0 throughout reset.
- Single request: req=4'b0010, wdata[1]=0xA5 → gnt=0010 after 1 edge, q=0xA5, qbar=0x5A, wr_done pulse after 2 edges.
- Contention: req=4'b1111 held, wdata[i]=0x10+i → grant order 0,1,2,3,0; q sequence 0x10,0x11,0x12,0x13; one write per cycle.
- Wrap: pointer=3, req=4'b0101 → grant to 0, then 2.
- Reset mid-GRANT: drop rst while gnt=0100 → gnt=0, q=0, no wr_done; the first grant after release goes to index 0 when req=1111.
- SHARED_REG_LOCK_EN: req[2]=1 and lock[2]=1 held 20 cycles with req[0]=1 → requester 2 gets 16 consecutive writes, then requester 0 is granted.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for the shared-register arbiter family.
// Combinational only: holds the FSM state type, the lock limit and the round-robin pick function.
// No flow control of its own.
package shared_reg_pkg;

    localparam int MAX_REQ  = 8;
    localparam int LOCK_MAX = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set req bit at or after ptr, searching upward and wrapping at n.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n = MAX_REQ
    );
        logic [2:0] win;
        int         idx;
        win = '0;
        for (int off = MAX_REQ - 1; off >= 0; off--) begin
            if (off < n) begin
                idx = int'(ptr) + off;
                if (idx >= n) idx = idx - n;
                if (req[3'(idx)]) win = 3'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// Round-robin priority encoder: first requester at or after ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid simply reports that some request is present.
module rr_picker
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    assign winner = PTR_W'(rr_pick(MAX_REQ'(req), 3'(ptr), N_REQ));
    assign valid  = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sequencing N_REQ writers into one shared register (optional lock: SHARED_REG_LOCK_EN).
// Latency: gnt one edge after req is sampled in IDLE, q and wr_done one edge later; back-to-back 1 write/cycle.
// Backpressure: requesters hold req/wdata until their gnt bit is seen, then drop req.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [PTR_W-1:0]       gnt_id,
    output logic                   wr_done,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qbar,
    output logic                   busy
);

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] gnt_id_nxt;
    logic [PTR_W-1:0] gnt_inc;
    logic [PTR_W-1:0] pick_ptr;
    logic [PTR_W-1:0] pick_win;
    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] gnt_nxt;
    logic             pick_vld;
    logic             load;
    logic             lock_keep;
    logic [WIDTH-1:0] wd_arr [N_REQ];
    logic [WIDTH-1:0] wsel;

    for (genvar i = 0; i < N_REQ; i++) begin : g_wd
        assign wd_arr[i] = wdata[i*WIDTH +: WIDTH];
    end
    assign wsel = wd_arr[gnt_id];

    assign gnt_inc = (gnt_id == PTR_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    // In GRANT the current grantee is masked out and the search starts just past it.
    assign pick_req = (state == GRANT) ? (req & ~gnt) : req;
    assign pick_ptr = (state == GRANT) ? gnt_inc : ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .winner (pick_win),
        .valid  (pick_vld)
    );

`ifdef SHARED_REG_LOCK_EN
    logic [3:0] lock_cnt;

    // lock_cnt counts writes already made in the current locked run.
    assign lock_keep = (state == GRANT) && lock[gnt_id] && req[gnt_id] &&
                       (lock_cnt != 4'(LOCK_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_keep ? lock_cnt + 4'd1 : '0;
        end
    end
`else
    assign lock_keep = 1'b0;
`endif

    // armed delays the first possible grant to the second edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            armed   <= 1'b0;
            ptr     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed   <= 1'b1;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= gnt_id_nxt;
            busy    <= (state_nxt == GRANT);
            wr_done <= load;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && pick_vld) state_nxt = GRANT;
            GRANT:   if (!lock_keep && !pick_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_id_nxt = gnt_id;
        ptr_nxt    = ptr;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (state_nxt == GRANT) gnt_id_nxt = pick_win;
            end
            GRANT: begin
                load = 1'b1;
                if (!lock_keep) begin
                    ptr_nxt = gnt_inc;
                    if (pick_vld) gnt_id_nxt = pick_win;
                end
            end
            default: ;
        endcase
        gnt_nxt = '0;
        if (state_nxt == GRANT) gnt_nxt = N_REQ'(1) << gnt_id_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= wsel;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = 2;

    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] wdata = '0;
`ifdef SHARED_REG_LOCK_EN
    logic [N-1:0]   lock  = '0;
`endif
    logic [N-1:0]   gnt;
    logic [PW-1:0]  gnt_id;
    logic           wr_done;
    logic [W-1:0]   q;
    logic [W-1:0]   qbar;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .PTR_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
`ifdef SHARED_REG_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .wr_done (wr_done),
        .q       (q),
        .qbar    (qbar),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: who holds the grant, where the search starts, what was written.
    bit           m_busy, m_wr, m_arm, m_keep;
    int           m_gid, m_ptr, m_run;
    logic [W-1:0] m_q;
    logic [N-1:0] m_others;

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[2'((p + k) % N)]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_arm = 0; m_keep = 0;
        m_gid = 0; m_ptr = 0; m_run = 0; m_q = '0;
    endtask

    task automatic model_step();
        if (m_busy) begin
            m_q  = wdata[m_gid*W +: W];
            m_wr = 1;
            m_keep = 0;
`ifdef SHARED_REG_LOCK_EN
            m_keep = lock[2'(m_gid)] && req[2'(m_gid)] && (m_run < 15);
`endif
            if (m_keep) begin
                m_run++;
            end else begin
                m_run = 0;
                m_ptr = (m_gid + 1) % N;
                m_others = req;
                m_others[2'(m_gid)] = 1'b0;
                if (m_others != 0) m_gid = first_from(m_others, m_ptr);
                else m_busy = 0;
            end
        end else begin
            m_wr = 0;
            if (m_arm && req != 0) begin
                m_gid  = first_from(req, m_ptr);
                m_busy = 1;
            end
        end
        m_arm = 1;
    endtask

    function automatic logic [23:0] model_vec();
        logic [N-1:0] g;
        g = m_busy ? (N'(1) << m_gid) : '0;
        return {g, PW'(m_gid), m_wr, m_q, ~m_q, m_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b0;
        model_reset();
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++;
            if ({gnt, busy, wr_done, q, qbar} !== {4'b0000, 1'b0, 1'b0, 8'h00, 8'hFF}) begin
                n_fail++;
                $display("FAIL reset_state: got %h expected %h", {gnt, busy, wr_done, q, qbar},
                         {4'b0000, 1'b0, 1'b0, 8'h00, 8'hFF});
            end
        end
        req = 4'b0001;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        rst = 1'b1;
        tick();
        n_chk++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL first_edge_no_grant: got %b expected 0000", gnt);
        end
        tick();
        n_chk++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL second_edge_grant: got %b expected 0001", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_single();
        wdata = {$urandom, $urandom} ;
        wdata[1*W +: W] = 8'hA5;
        req = 4'b0010;
        tick();
        n_chk++;
        if ({gnt, gnt_id, busy, wr_done} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected %b", {gnt, gnt_id, busy, wr_done},
                     {4'b0010, 2'd1, 1'b1, 1'b0});
        end
        req = 4'b0000;
        tick();
        n_chk++;
        if ({q, qbar, wr_done, gnt, busy} !== {8'hA5, 8'h5A, 1'b1, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_write: got %h expected %h", {q, qbar, wr_done, gnt, busy},
                     {8'hA5, 8'h5A, 1'b1, 4'b0000, 1'b0});
        end
        tick();
        n_chk++;
        if ({wr_done, q} !== {1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_pulse_end: got %h expected %h", {wr_done, q}, {1'b0, 8'hA5});
        end
    endtask

    task automatic test_contention();
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b0000;
        apply_reset(2);
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++;
            if (gnt !== (4'b0001 << (k % 4))) begin
                n_fail++;
                $display("FAIL contention_gnt%0d: got %b expected %b", k, gnt, 4'b0001 << (k % 4));
            end
            if (k > 0) begin
                n_chk++;
                if ({wr_done, q} !== {1'b1, 8'(8'h10 + k - 1)}) begin
                    n_fail++;
                    $display("FAIL contention_q%0d: got %h expected %h", k, {wr_done, q},
                             {1'b1, 8'(8'h10 + k - 1)});
                end
            end
        end
        req = 4'b0000;
        tick();
        n_chk++;
        if ({wr_done, q, busy} !== {1'b1, 8'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL contention_last: got %h expected %h", {wr_done, q, busy}, {1'b1, 8'h10, 1'b0});
        end
        tick();
    endtask

    task automatic test_wrap();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0101;
        tick();
        n_chk++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first: got %b expected 0001", gnt);
        end
        req = 4'b0100;
        tick();
        n_chk++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_second: got %b expected 0100", gnt);
        end
        req = 4'b0000;
        tick();
        n_chk++;
        if ({q, wr_done} !== {8'h12, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_write: got %h expected %h", {q, wr_done}, {8'h12, 1'b1});
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b0100;
        tick();
        n_chk++;
        if ({gnt, q} !== {4'b0100, 8'h12}) begin
            n_fail++;
            $display("FAIL midrst_setup: got %h expected %h", {gnt, q}, {4'b0100, 8'h12});
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({gnt, busy, wr_done, q, qbar} !== {4'b0000, 1'b0, 1'b0, 8'h00, 8'hFF}) begin
            n_fail++;
            $display("FAIL midrst_clear: got %h expected %h", {gnt, busy, wr_done, q, qbar},
                     {4'b0000, 1'b0, 1'b0, 8'h00, 8'hFF});
        end
        tick();
        n_chk++;
        if ({wr_done, q} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst_no_write: got %h expected %h", {wr_done, q}, {1'b0, 8'h00});
        end
        req = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        n_chk++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_first_grant: got %b expected 0001", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

`ifdef SHARED_REG_LOCK_EN
    task automatic test_lock();
        int grants[$];
        int run;
        req = '0;
        lock = '0;
        apply_reset(2);
        tick();
        req = 4'b0100;
        lock = 4'b0100;
        tick();
        grants.push_back(int'(gnt_id));
        req = 4'b0101;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy) grants.push_back(int'(gnt_id));
        end
        run = 0;
        while (run < grants.size() && grants[run] == 2) run++;
        n_chk++;
        if (run != 16) begin
            n_fail++;
            $display("FAIL lock_run_length: got %0d expected 16", run);
        end
        n_chk++;
        if (grants.size() < 17 || grants[16] != 0) begin
            n_fail++;
            $display("FAIL lock_next_winner: got %0d expected 0", grants.size() < 17 ? -1 : grants[16]);
        end
        req = '0;
        lock = '0;
        tick();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [23:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            tick();
            got = {gnt, gnt_id, wr_done, q, qbar, busy};
            exp = model_vec();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, got, exp);
            end
            req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            wdata = {$urandom};
`ifdef SHARED_REG_LOCK_EN
            lock  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
`endif
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                rst = 1'b0;
                model_reset();
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_reset_mid_grant();
`ifdef SHARED_REG_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
